// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, HI/LO select, default latencies.
// The MADD/MADDU/MSUB/MSUBU family is classified as a multiply only when MDU_MADD_EN is defined.
package mdu_sched_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic SEL_HI = 1'b0;
  localparam logic SEL_LO = 1'b1;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit HI/LO result for a multi-cycle md op, from operands and current HI/LO.
// MDU_MADD_EN adds the multiply-accumulate/subtract forms; o_res_we is low for divide by zero.
module mdu_arith
  import mdu_sched_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output hilo_t       o_res,
  output logic        o_res_we
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_div_s;
  logic [31:0] w_b_div_u;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;

  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide on magnitudes; 0x80000000 survives as its own magnitude, so the
  // overflow case 0x80000000 / -1 falls out as 0x80000000 rem 0 with no special case.
  assign w_a_mag   = i_a[31] ? -i_a : i_a;
  assign w_b_mag   = i_b[31] ? -i_b : i_b;
  assign w_b_div_s = (i_b == 32'd0) ? 32'd1 : w_b_mag;
  assign w_b_div_u = (i_b == 32'd0) ? 32'd1 : i_b;
  assign w_q_mag   = w_a_mag / w_b_div_s;
  assign w_r_mag   = w_a_mag % w_b_div_s;
  assign w_q_u     = i_a / w_b_div_u;
  assign w_r_u     = i_a % w_b_div_u;

`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {i_hi, i_lo};
`endif

  always_comb begin
    o_res    = {i_hi, i_lo};
    o_res_we = 1'b0;
    case (i_op)
      OP_MULT: begin
        o_res    = w_prod_s;
        o_res_we = 1'b1;
      end
      OP_MULTU: begin
        o_res    = w_prod_u;
        o_res_we = 1'b1;
      end
      OP_DIV: begin
        o_res.lo = (i_a[31] ^ i_b[31]) ? -w_q_mag : w_q_mag;
        o_res.hi = i_a[31] ? -w_r_mag : w_r_mag;
        o_res_we = (i_b != 32'd0);
      end
      OP_DIVU: begin
        o_res.lo = w_q_u;
        o_res.hi = w_r_u;
        o_res_we = (i_b != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        o_res    = w_acc + w_prod_s;
        o_res_we = 1'b1;
      end
      OP_MADDU: begin
        o_res    = w_acc + w_prod_u;
        o_res_we = 1'b1;
      end
      OP_MSUB: begin
        o_res    = w_acc - w_prod_s;
        o_res_we = 1'b1;
      end
      OP_MSUBU: begin
        o_res    = w_acc - w_prod_u;
        o_res_we = 1'b1;
      end
`endif
      default: begin
        o_res    = {i_hi, i_lo};
        o_res_we = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// EX-stage multiply/divide sequencer: owns HI/LO, times multi-cycle ops with a down-counter, stalls ID.
// Build option MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (multiply latency).
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [0:0]  o_dbg_state
);

  localparam logic [3:0] L_MULT = 4'(MULT_LAT);
  localparam logic [3:0] L_DIV  = 4'(DIV_LAT);

  logic [3:0]  r_cnt;
  hilo_t       r_pend;
  logic        r_pend_we;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_mul;
  logic        w_div;
  logic        w_lat_op;
  hilo_t       w_res;
  logic        w_res_we;

  mdu_arith u_arith (
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_res    (w_res),
    .o_res_we (w_res_we)
  );

  assign w_mul    = is_mul_op(op);
  assign w_div    = is_div_op(op);
  assign w_lat_op = w_mul | w_div;

  // State is IDLE exactly when the counter is zero, so it is decoded rather than stored.
  assign o_dbg_state = (r_cnt != 4'd0) ? ST_BUSY : ST_IDLE;
  assign busy        = (o_dbg_state == ST_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_pend    <= '0;
      r_pend_we <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else if (busy) begin
      // A start while busy is dropped; the pending result commits on the 1->0 step.
      r_cnt <= r_cnt - 4'd1;
      if ((r_cnt == 4'd1) && r_pend_we) begin
        r_hi <= r_pend.hi;
        r_lo <= r_pend.lo;
      end
    end else if (start) begin
      if (w_lat_op) begin
        r_cnt     <= w_mul ? L_MULT : L_DIV;
        r_pend    <= w_res;
        r_pend_we <= w_res_we;
      end else if (op == OP_MTHI) begin
        r_hi <= a;
      end else if (op == OP_MTLO) begin
        r_lo <= a;
      end
    end
  end

  assign rd_data   = (rd_sel == SEL_LO) ? r_lo : r_hi;
  assign stall_req = md_use_d & (busy | (start & w_lat_op));
  assign hi        = r_hi;
  assign lo        = r_lo;

  a_no_start_while_busy: assert property (@(posedge clk) disable iff (rst) !(start && busy));

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized + directed bench for mdu_sched; long ops are scoreboarded by a monitor on busy edges.
// Define MDU_MADD_EN for both RTL and bench to exercise the accumulate ops.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_d;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [0:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          lat;
    logic [63:0] old_v;
    logic [63:0] new_v;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .md_use_d    (md_use_d),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .busy        (busy),
    .stall_req   (stall_req),
    .hi          (hi),
    .lo          (lo),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] h, input logic [31:0] l, output int lat);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     cur, res;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    cur = {h, l};
    res = cur;
    lat = 0;
    case (o)
      OP_MULT:  begin lat = MULT_LAT; res = 64'(sx * sy); end
      OP_MULTU: begin lat = MULT_LAT; res = ux * uy; end
      OP_DIV:   begin lat = DIV_LAT; if (y != 32'd0) res = {32'(sx % sy), 32'(sx / sy)}; end
      OP_DIVU:  begin lat = DIV_LAT; if (y != 32'd0) res = {32'(ux % uy), 32'(ux / uy)}; end
      OP_MTHI:  res = {x, l};
      OP_MTLO:  res = {h, x};
`ifdef MDU_MADD_EN
      OP_MADD:  begin lat = MULT_LAT; res = cur + 64'(sx * sy); end
      OP_MADDU: begin lat = MULT_LAT; res = cur + ux * uy; end
      OP_MSUB:  begin lat = MULT_LAT; res = cur - 64'(sx * sy); end
      OP_MSUBU: begin lat = MULT_LAT; res = cur - ux * uy; end
`endif
      default:  res = cur;
    endcase
    return res;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input bit chk_stall);
    int          lat;
    int          n;
    logic [63:0] ov, nv;
    ov = {m_hi, m_lo};
    nv = model(o, x, y, m_hi, m_lo, lat);
    @(negedge clk);
    md_use_d = chk_stall;
    rd_sel   = SEL_LO;
    start    = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    if (lat > 0) exp_q.push_back('{lat, ov, nv});
    #1;
    if (chk_stall) check("stall_start", 64'(stall_req), 64'(lat > 0));
    @(negedge clk);
    start = 1'b0;
    op    = OP_NOP;
    a     = $urandom;
    b     = $urandom;
    m_hi  = nv[63:32];
    m_lo  = nv[31:0];
    n     = 0;
    #1;
    while (busy === 1'b1 && n < 40) begin
      if (chk_stall) check("stall_busy", 64'(stall_req), 64'd1);
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) check("idle_timeout", 64'd1, 64'd0);
    check("busy_cycles", 64'(n), 64'(lat));
    check("hilo_after", {hi, lo}, nv);
    if (chk_stall) begin
      check("stall_end", 64'(stall_req), 64'd0);
      check("rd_lo_after", 64'(rd_data), 64'(nv[31:0]));
    end
    md_use_d = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    bit   prev_busy;
    bit   have;
    int   cnt;
    exp_t cur;
    prev_busy = 1'b0;
    have      = 1'b0;
    cnt       = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        have      = 1'b0;
        prev_busy = 1'b0;
        cnt       = 0;
        continue;
      end
      if (busy && !prev_busy) begin
        cnt = 0;
        if (exp_q.size() == 0) begin
          check("busy_unexpected", 64'd1, 64'd0);
          have = 1'b0;
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
        end
      end
      if (busy) begin
        cnt++;
        if (have) check("hilo_hold", {hi, lo}, cur.old_v);
      end else if (prev_busy && have) begin
        check("sb_busy_len", 64'(cnt), 64'(cur.lat));
        check("sb_commit", {hi, lo}, cur.new_v);
        have = 1'b0;
      end
      prev_busy = busy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] op_tab [12];
    op_tab = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_NOP,
               OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, 4'd15};
    rst = 1'b1; start = 1'b0; op = OP_NOP; a = 32'd0; b = 32'd0; md_use_d = 1'b0; rd_sel = SEL_HI;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_rd", 64'(rd_data), 64'd0);

    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
    check("mult_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo), 64'hFFFFFFFA);

    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_hi", 64'(hi), 64'hFFFFFFFF);

    issue(OP_MTHI, 32'h11, 32'd0, 1'b0);
    issue(OP_MTLO, 32'h22, 32'd0, 1'b1);
    issue(OP_DIV, 32'd1234, 32'd0, 1'b0);
    check("div0_hilo", {hi, lo}, 64'h00000011_00000022);

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf", {hi, lo}, 64'h00000000_80000000);

    issue(OP_NOP, 32'h1234, 32'h5678, 1'b0);
    issue(4'd15, 32'h1234, 32'h5678, 1'b1);

    for (int i = 0; i < 40; i++) begin
      issue(op_tab[$urandom_range(0, 11)], rand_val(), rand_val(), 1'($urandom_range(0, 1)));
      rd_sel = SEL_HI;
      #1;
      check("rd_hi", 64'(rd_data), 64'(m_hi));
      rd_sel = SEL_LO;
      #1;
      check("rd_lo", 64'(rd_data), 64'(m_lo));
    end

`ifdef MDU_MADD_EN
    issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
    issue(OP_MADDU, 32'd1, 32'd1, 1'b1);
    check("maddu_hilo", {hi, lo}, 64'h00000001_00000000);
`endif

    // Reset in the middle of a divide: nothing commits, now or later.
    issue(OP_MTHI, 32'h55, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    exp_q.push_back('{DIV_LAT, {m_hi, m_lo}, {32'd1, 32'd333}});
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    repeat (15) @(negedge clk);
    #1;
    check("midrst_late_busy", 64'(busy), 64'd0);
    check("midrst_late_hilo", {hi, lo}, 64'd0);

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multiply/divide sequencer for the 5-stage pipeline. It owns the HI/LO register pair and issues MULT/MULTU/DIV/DIVU to a multi-cycle model.
- It tracks busy time with a down-counter and raises a stall request to the hazard/forwarding unit.
- Sits beside the ALU in the EX stage. Operands arrive already forwarded.

Parameters:
- MULT_LAT, 5, cycles busy after a multiply start (1..15).
- DIV_LAT, 10, cycles busy after a divide start (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  valid md op in EX this cycle; 0 when EX holds a bubble
- op  in  4  md opcode (package encoding)
- a  in  32  operand rs (forwarded)
- b  in  32  operand rt (forwarded)
- md_use_d  in  1  instruction in ID is any md op (incl. MFHI/MFLO)
- rd_sel  in  1  0=HI, 1=LO, for MFHI/MFLO read
- rd_data  out  32  selected HI/LO, combinational
- busy  out  1  registered, high while counter nonzero
- stall_req  out  1  combinational stall to hazard unit
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clk and rst, as elsewhere in the pipeline.
- Reset: hi=lo=0, busy=0, counter=0, state IDLE, pending results=0. Reset mid-operation aborts the operation; nothing is committed.
- States:
  - IDLE: counter==0.
  - BUSY: counter!=0.
- IDLE with start, op in {MULT,MULTU,DIV,DIVU}:
  - Latch op, a, b and compute the 64-bit pending {hi,lo}.
  - Load counter with MULT_LAT or DIV_LAT; go to BUSY on the next edge.
- BUSY: counter decrements every cycle. On the edge where it goes 1->0, hi/lo take the pending value and busy falls.
- Latency: start at edge t. busy=1 for cycles t+1..t+LAT. The new hi/lo are visible from cycle t+LAT+1.
- MTHI/MTLO in IDLE: write a to hi or lo at the next edge. Zero latency, busy stays 0.
- MFHI/MFLO: rd_data = rd_sel ? lo : hi. No start needed. A read is never returned while an op is pending, because of stall_req.
- stall_req = md_use_d & (busy | (start & op is MULT/MULTU/DIV/DIVU)).
- start while busy=1 cannot occur, because stall_req holds it in ID. It is ignored if it does occur; the verification assertion fires.
- Arithmetic:
  - MULT: signed 32x32->64; hi = upper word, lo = lower word.
  - MULTU: unsigned 32x32->64.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of a.
  - DIVU: unsigned; lo = quotient, hi = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b==0): the counter still runs DIV_LAT cycles; hi/lo keep their old values at completion.
- op NOP or an undefined code with start=1: no state change.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds MADD, MADDU, MSUB and MSUBU.
  - Pending value is {hi,lo} ± the 64-bit product, wrap modulo 2^64.
  - Uses MULT_LAT. HI/LO are sampled at start.
- Not defined: those codes are treated as undefined (no state change). Counter and stall logic are unchanged.

Decomposition:
- Shared package (def.v style include):
  - 4-bit opcode constants: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - HI/LO select constants.
  - Default latencies.
- One natural sub-module, mdu_arith: purely combinational 64-bit result computation from op, a, b and the current hi/lo. It is instantiated once.
- Counter, FSM, commit and stall logic stay in mdu_sched.

Test Plan:
- MULT, a=0xFFFFFFFE (-2), b=3, start at t:
  - busy high for cycles t+1..t+5.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA at t+6; unchanged before then.
- DIVU, a=100, b=7: after 10 cycles lo=14, hi=2. DIV, a=-7, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV with b=0 after MTHI 0x11, MTLO 0x22: busy for 10 cycles, then hi=0x11, lo=0x22.
- MULT start with md_use_d=1 (MFLO in ID):
  - stall_req=1 in the start cycle and through the last busy cycle.
  - Drops in cycle t+6; rd_data then equals the new lo.
- rst asserted mid-DIV (cycle t+4): busy=0, hi=lo=0 the next cycle, and no later commit.
- With MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then MADDU a=1, b=1 -> after 5 cycles hi=1, lo=0.
